// File: rtl/hsynth_audio_pkg.sv
// Shared definitions for the synth audio path: default widths, the playback
// serializer state encoding and the stereo half-select indices.
package hsynth_audio_pkg;

   localparam int unsigned DATA_W_DEF = 24;
   localparam int unsigned CNT_W_DEF  = 16;

   // Serializer sequencing: idle/silent, waiting for a frame start, running.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      RUN  = 2'd2
   } tx_state_e;

   // Half index within a packed stereo word: left sits in the upper half.
   localparam int unsigned HALF_LEFT  = 1;
   localparam int unsigned HALF_RIGHT = 0;

endpackage

// File: rtl/hsynth_edge_sync.sv
// Two-flop synchronizer followed by a delay flop, producing the synced level
// and single-cycle rise/fall strokes for an oversampled asynchronous input.
// Ports:
//   clk, reset_n : interface clock, async active-low reset
//   d            : asynchronous input
//   q            : synchronized level
//   rise_c       : combinational, synced 0->1 seen this cycle
//   fall_c       : combinational, synced 1->0 seen this cycle
module hsynth_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic q_dly;

   // Synchronizer chain plus one-cycle history for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta  <= 1'b0;
         q     <= 1'b0;
         q_dly <= 1'b0;
      end else begin
         meta  <= d;
         q     <= meta;
         q_dly <= q;
      end
   end

   assign rise_c = q & ~q_dly;
   assign fall_c = ~q & q_dly;

endmodule

// File: rtl/hsynth_i2s_tx.sv
// Philips-I2S playback serializer. Oversamples bclk/lrclk on clk, pops one
// stereo word per frame from a show-ahead FIFO and shifts it out MSB-first on
// dacdat with the one-bit I2S delay after each channel edge.
// Ports:
//   clk, reset_n   : interface clock, async active-low reset
//   enable         : 1 = run, 0 = idle with silent output
//   bclk, lrclk    : bit/frame clocks (asynchronous, sampled only)
//   fifo_empty     : playback FIFO empty
//   fifo_rdata     : FIFO head word {left, right}
//   fifo_rd        : pop strobe, same cycle as the left-start bclk fall
//   dacdat         : serial data to the DAC
//   underrun       : pulse when a frame starts with the FIFO empty
//   underrun_clr   : synchronous clear of underrun_cnt
//   underrun_cnt   : saturating underrun count
module hsynth_i2s_tx
   import hsynth_audio_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                bclk,
   input  logic                lrclk,
   input  logic                fifo_empty,
   input  logic [2*DATA_W-1:0] fifo_rdata,
   output logic                fifo_rd,
   output logic                dacdat,
   output logic                underrun,
   input  logic                underrun_clr,
   output logic [CNT_W-1:0]    underrun_cnt
);

   localparam int unsigned       BCNT_W   = $clog2(DATA_W + 1);
   localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W);

   tx_state_e state_q, state_d;

   logic bclk_s, bclk_rise, bfall;
   logic lr_s, lr_rise, lr_fall;
   logic lr_q;
   logic chan_start, left_start, right_start;
   logic take_left, load_right, shift;
   logic unused_edges;

   logic [2*DATA_W-1:0] hold;
   logic [DATA_W-1:0]   shreg;
   logic [BCNT_W-1:0]   bit_cnt;

   hsynth_edge_sync u_bclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bclk),
      .q       (bclk_s),
      .rise_c  (bclk_rise),
      .fall_c  (bfall)
   );

   hsynth_edge_sync u_lrclk_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (lrclk),
      .q       (lr_s),
      .rise_c  (lr_rise),
      .fall_c  (lr_fall)
   );

   // Channel edges are judged against lr_q, which only moves on bclk falls.
   assign unused_edges = ^{bclk_s, bclk_rise, lr_rise, lr_fall};
   assign chan_start   = bfall & (lr_s != lr_q);
   assign left_start   = chan_start & ~lr_s;
   assign right_start  = chan_start & lr_s;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and per-cycle actions; enable low overrides everything.
   always_comb begin
      state_d    = state_q;
      take_left  = 1'b0;
      load_right = 1'b0;
      shift      = 1'b0;
      fifo_rd    = 1'b0;
      underrun   = 1'b0;
      case (state_q)
         IDLE: state_d = SYNC;
         SYNC: begin
            if (left_start) begin
               state_d   = RUN;
               take_left = 1'b1;
            end
         end
         RUN: begin
            if (left_start)       take_left  = 1'b1;
            else if (right_start) load_right = 1'b1;
            else if (bfall)       shift      = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (!enable) begin
         state_d    = IDLE;
         take_left  = 1'b0;
         load_right = 1'b0;
         shift      = 1'b0;
      end
      fifo_rd  = take_left & ~fifo_empty;
      underrun = take_left & fifo_empty;
   end

   // Frame phase tracking, sample hold and shift register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lr_q    <= 1'b0;
         hold    <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         dacdat  <= 1'b0;
      end else begin
         if (bfall) lr_q <= lr_s;
         if (take_left) begin
            // Empty FIFO plays a silent frame.
            hold    <= fifo_empty ? '0 : fifo_rdata;
            shreg   <= fifo_empty ? '0 : fifo_rdata[HALF_LEFT*DATA_W +: DATA_W];
            bit_cnt <= '0;
         end else if (load_right) begin
            shreg   <= hold[HALF_RIGHT*DATA_W +: DATA_W];
            bit_cnt <= '0;
         end
         // On channel-start falls dacdat holds: that is the I2S one-bit delay.
         if (!enable) begin
            dacdat <= 1'b0;
         end else if (shift) begin
            if (bit_cnt != BIT_LAST) begin
               dacdat  <= shreg[DATA_W-1];
               shreg   <= {shreg[DATA_W-2:0], 1'b0};
               bit_cnt <= bit_cnt + BCNT_W'(1);
            end else begin
               dacdat <= 1'b0;
            end
         end
      end
   end

   // Saturating underrun counter; a coincident clear keeps the new event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun_cnt <= '0;
      end else if (underrun_clr) begin
         underrun_cnt <= underrun ? CNT_W'(1) : '0;
      end else if (underrun && (underrun_cnt != '1)) begin
         underrun_cnt <= underrun_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hsynth_i2s_tx.sv
// Directed scoreboard bench for hsynth_i2s_tx: per-bclk expected dacdat,
// pop and underrun values are queued before each slot is driven.
module tb_hsynth_i2s_tx;

   localparam int unsigned DATA_W  = 24;
   localparam int unsigned CNT_W   = 4;   // narrow so saturation is reachable
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic                clk;
   logic                reset_n;
   logic                enable;
   logic                bclk;
   logic                lrclk;
   logic                fifo_empty;
   logic [2*DATA_W-1:0] fifo_rdata;
   logic                fifo_rd;
   logic                dacdat;
   logic                underrun;
   logic                underrun_clr;
   logic [CNT_W-1:0]    underrun_cnt;

   hsynth_i2s_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .bclk         (bclk),
      .lrclk        (lrclk),
      .fifo_empty   (fifo_empty),
      .fifo_rdata   (fifo_rdata),
      .fifo_rd      (fifo_rd),
      .dacdat       (dacdat),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .underrun_cnt (underrun_cnt)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic bit_v;
      logic rd;
      logic ur;
   } exp_t;

   exp_t                exp_q[$];
   logic [2*DATA_W-1:0] fifo_q[$];
   int                  total = 0;
   int                  bad   = 0;
   logic                carry_bit;
   logic                prev_bit;
   int                  exp_cnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   // Queue n slot positions: position 0 repeats the previous bit, then MSB-first data, then zeros.
   task automatic push_slot(input int n, input logic [DATA_W-1:0] data,
                            input bit active, input bit rd, input bit ur);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.rd = (i == 0) && rd;
         e.ur = (i == 0) && ur;
         if (!active)          e.bit_v = 1'b0;
         else if (i == 0)      e.bit_v = carry_bit;
         else if (i <= DATA_W) e.bit_v = data[DATA_W - i];
         else                  e.bit_v = 1'b0;
         carry_bit = e.bit_v;
         exp_q.push_back(e);
      end
   endtask

   // One bclk period of 16 clk: fall + lrclk update, then checks at 2 and 3 clk after the fall.
   task automatic bclk_cycle(input logic lr, input bit clr);
      exp_t e;
      logic seen_rd;
      logic [2*DATA_W-1:0] junk;
      @(negedge clk);
      bclk  = 1'b0;
      lrclk = lr;
      @(negedge clk);
      @(negedge clk);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("dac_hold", dacdat, prev_bit);
      check("fifo_rd", fifo_rd, e.rd);
      check("underrun", underrun, e.ur);
      seen_rd = fifo_rd;
      if (clr) underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      if (seen_rd && fifo_q.size() != 0) begin
         junk = fifo_q.pop_front();
         drive_fifo();
      end
      check("rd_one_cycle", fifo_rd, 1'b0);
      check("dacdat", dacdat, e.bit_v);
      prev_bit = e.bit_v;
      repeat (4) @(negedge clk);
      @(negedge clk);
      bclk = 1'b1;
      repeat (7) @(negedge clk);
   endtask

   // Full active frame of n bclk per channel.
   task automatic frame(input int n, input bit clr);
      logic [2*DATA_W-1:0] w;
      bit rd, ur;
      if (fifo_q.size() != 0) begin
         w = fifo_q[0]; rd = 1'b1; ur = 1'b0;
         if (clr) exp_cnt = 0;
      end else begin
         w = '0; rd = 1'b0; ur = 1'b1;
         if (clr)                    exp_cnt = 1;
         else if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      push_slot(n, w[2*DATA_W-1:DATA_W], 1'b1, rd, ur);
      push_slot(n, w[DATA_W-1:0], 1'b1, 1'b0, 1'b0);
      bclk_cycle(1'b0, clr);
      repeat (n - 1) bclk_cycle(1'b0, 1'b0);
      repeat (n) bclk_cycle(1'b1, 1'b0);
      check("underrun_cnt", underrun_cnt, 32'(exp_cnt));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dacdat"}, dacdat, 1'b0);
      check({tag, "_fifo_rd"}, fifo_rd, 1'b0);
      check({tag, "_underrun"}, underrun, 1'b0);
      check({tag, "_cnt"}, underrun_cnt, 32'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      enable       = 1'b0;
      bclk         = 1'b1;
      lrclk        = 1'b1;
      underrun_clr = 1'b0;
      carry_bit    = 1'b0;
      prev_bit     = 1'b0;
      exp_cnt      = 0;
      drive_fifo();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);
      enable = 1'b1;

      // Partial right slot before any left start: silent, no pops.
      push_slot(4, '0, 1'b0, 1'b0, 1'b0);
      repeat (4) bclk_cycle(1'b1, 1'b0);

      // Normal playback, two frames of 32 bclk per channel.
      fifo_q.push_back({24'hA5A5A5, 24'h5A5A5A});
      fifo_q.push_back({24'h123456, 24'hABCDEF});
      drive_fifo();
      frame(32, 1'b0);
      frame(32, 1'b0);

      // Empty FIFO: one underrun, silent frame.
      frame(32, 1'b0);

      // Run the counter into saturation with short frames, then clear with a coincident underrun.
      repeat (15) frame(4, 1'b0);
      frame(4, 1'b1);
      @(negedge clk);
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      check("clr_alone", underrun_cnt, 32'd0);

      // Disable mid-left-slot, re-enable mid-right-slot.
      fifo_q.push_back({24'hC3C3C3, 24'h3C3C3C});
      drive_fifo();
      push_slot(10, 24'hC3C3C3, 1'b1, 1'b1, 1'b0);
      repeat (10) bclk_cycle(1'b0, 1'b0);
      enable = 1'b0;
      @(negedge clk);
      check("en_off_dacdat", dacdat, 1'b0);
      check("en_off_rd", fifo_rd, 1'b0);
      carry_bit = 1'b0;
      prev_bit  = 1'b0;
      fifo_q.push_back({24'h876543, 24'h2468AC});
      drive_fifo();
      push_slot(22, '0, 1'b0, 1'b0, 1'b0);
      repeat (22) bclk_cycle(1'b0, 1'b0);
      push_slot(10, '0, 1'b0, 1'b0, 1'b0);
      repeat (10) bclk_cycle(1'b1, 1'b0);
      enable = 1'b1;
      push_slot(22, '0, 1'b0, 1'b0, 1'b0);
      repeat (22) bclk_cycle(1'b1, 1'b0);
      frame(32, 1'b0);

      // Give the counter a nonzero value, then reset mid-frame while dacdat is high.
      frame(4, 1'b0);
      fifo_q.push_back({24'hFFFFFF, 24'hFFFFFF});
      drive_fifo();
      push_slot(12, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
      repeat (12) bclk_cycle(1'b0, 1'b0);
      check("pre_reset_dacdat", dacdat, 1'b1);
      reset_n = 1'b0;
      @(negedge clk);
      check_all_zero("mid_reset");
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      exp_cnt   = 0;
      carry_bit = 1'b0;
      prev_bit  = 1'b0;
      push_slot(20, '0, 1'b0, 1'b0, 1'b0);
      repeat (20) bclk_cycle(1'b0, 1'b0);
      push_slot(32, '0, 1'b0, 1'b0, 1'b0);
      repeat (32) bclk_cycle(1'b1, 1'b0);

      // Short slots truncate to the top 15 bits, then a full frame recovers.
      fifo_q.push_back({24'hF0F0F1, 24'h9ABCDF});
      fifo_q.push_back({24'h0F0F0F, 24'h7FFFFE});
      fifo_q.push_back({24'hDEADBE, 24'hCAFE55});
      drive_fifo();
      frame(16, 1'b0);
      frame(16, 1'b0);
      frame(32, 1'b0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hsynth_i2s_tx.md
# hsynth_i2s_tx

Playback serializer sitting directly downstream of the synth clock controller. It consumes the selected `bclk`/`lrclk` pair, pops one stereo sample per frame from a show-ahead playback FIFO, and drives Philips-I2S `dacdat` MSB-first with the standard one-bclk delay. All logic runs on the interface clock `clk`; `bclk` and `lrclk` are oversampled, never used as clocks.

## Interface
- `DATA_W`, 24: sample width per channel.
- `CNT_W`, 16: underrun counter width.
- `clk` in 1: interface clock; must give ≥3 `clk` cycles in each `bclk` high and low phase.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = run, 0 = idle and drive silence.
- `bclk` in 1: bit clock from the clock controller, asynchronous to `clk`.
- `lrclk` in 1: frame clock, asynchronous to `clk`; 0 = left, 1 = right.
- `fifo_empty` in 1: playback FIFO empty.
- `fifo_rdata` in 2*DATA_W: show-ahead head word; left in `[2*DATA_W-1:DATA_W]`, right in `[DATA_W-1:0]`.
- `fifo_rd` out 1: one-cycle pop strobe. Reset value 0.
- `dacdat` out 1: serial data to the DAC. Reset value 0.
- `underrun` out 1: one-cycle pulse when a frame starts with the FIFO empty. Reset value 0.
- `underrun_clr` in 1: synchronous clear of `underrun_cnt`.
- `underrun_cnt` out CNT_W: saturating underrun count. Reset value 0.

## Operation
- **Input sync:** `bclk` and `lrclk` each pass through a 2-FF synchronizer, then a delay FF.
  - `bfall` = previous synced `bclk` is 1 and current is 0.
  - Synced `lrclk` is sampled only on `bfall` into `lr_q`. Both synchronizer paths have equal depth.
- **Frame edge:** on `bfall`, if the synced `lrclk` differs from `lr_q`, this is a channel start.
  - A 1→0 change is a left start (frame start).
  - A 0→1 change is a right start.
- **State machine:**
  - IDLE: entered from reset and whenever `enable`=0, from any state, in the same cycle. Outputs: `dacdat`=0, no pops. Goes to SYNC when `enable`=1.
  - SYNC: waits for the first left start, then goes to RUN. No pops before that point.
  - RUN: normal operation.
- **Left start (RUN):**
  - If `fifo_empty`=0: assert `fifo_rd` for exactly one cycle, in the same cycle as `bfall`. Latch `fifo_rdata` into `hold`.
  - If `fifo_empty`=1: load 0 into `hold`, pulse `underrun`, and increment `underrun_cnt`.
  - Load the left half of the new `hold` into `shreg`.
- **Right start:** load the right half of `hold` into `shreg`. No FIFO access.
- **Shifting (RUN, every `bfall`):**
  - On a channel-start `bfall`, `dacdat` keeps its previous value. This is the I2S one-bit delay.
  - On each following `bfall`, `dacdat` ← `shreg` MSB and `shreg` shifts left with zero fill.
  - Bit counter: `$clog2(DATA_W+1)` bits; once DATA_W bits have gone out, `dacdat` stays 0 for the rest of the slot.
  - A short slot (channel edge before DATA_W bits) truncates and reloads. A long slot pads with zeros.
- **Counter:** `underrun_cnt` saturates at all-ones. If `underrun_clr` and an underrun occur in the same cycle, the result is 1.
- **Reset mid-frame:** all state and outputs return to reset values. After release the block restarts from SYNC only if `enable`=1.

## Timing
- `dacdat` updates 3 `clk` cycles after the physical `bclk` falling edge (2 synchronizer stages + output register). This is stable well before the DAC samples on the rising edge, given the minimum phase length above.
- `fifo_rd` rises 2 `clk` cycles after the physical `bclk` fall at a left start, and lasts 1 cycle.
- `fifo_rdata` is sampled in the same cycle as `fifo_rd`.
- `underrun` is asserted in the same cycle as the would-be `fifo_rd`.
- `enable` falling forces `dacdat`=0 on the next `clk` edge.

## Structure
- Shared package `hsynth_audio_pkg`:
  - `DATA_W` default.
  - State enum `{IDLE, SYNC, RUN}`.
  - Left/right half-select constants.
- One sub-module, `hsynth_edge_sync`: 2-FF synchronizer + delay FF with rise/fall outputs. Instantiated for `bclk` and `lrclk`.
- Estimated size: around 180 lines of RTL total.

## Test plan
All scenarios use `clk` 50 MHz, `bclk` period 16 `clk`, 64 `bclk` per frame, `DATA_W`=24.
1. FIFO holds {L=0xA5A5A5, R=0x5A5A5A}, `enable`=1 → after the first left start, `dacdat` serializes 1010…(24 bits), then 8 zero bits, then 0x5A5A5A MSB-first. There is exactly one `fifo_rd` per frame.
2. Bit alignment: MSB appears on the second `bfall` after the `lrclk` edge; `dacdat` transitions land 3 `clk` after each physical fall.
3. FIFO empty at a left start → `underrun` pulses once; 64 zero bits go out; `underrun_cnt`=1; no `fifo_rd`.
4. Counter: preload 0xFFFE underruns, then 3 more → `underrun_cnt`=0xFFFF. `underrun_clr` coincident with an underrun → 1.
5. `enable` 1→0 mid-left-slot → `dacdat`=0 next cycle, no further pops. Re-enable mid-right-slot → no pop until the next left start.
6. `reset_n` pulsed mid-frame → all outputs 0. Short frame (16 `bclk`/channel) → only the top 15 bits are sent, then reload, with no lockup.
